// File: rtl/redmule_pkg.sv
// Shared types and defaults for the RedMulE stream arbiter.
// Optional aging feature is enabled by defining REDMULE_ARB_AGING_EN.
package redmule_pkg;

    typedef enum logic {ArbIdle, ArbBurst} arb_state_e;

    localparam int unsigned ARB_NREQ     = 4;
    localparam int unsigned ARB_LEN_W    = 16;
    localparam int unsigned ARB_MAX_WAIT = 64;

    localparam int unsigned ARB_X = 0;
    localparam int unsigned ARB_W = 1;
    localparam int unsigned ARB_Y = 2;
    localparam int unsigned ARB_Z = 3;

    function automatic int unsigned arb_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/redmule_rr_pick.sv
// Combinational round-robin picker: first set request at or after the start index.
module redmule_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int unsigned pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = (32'(start) + off) % N;
            if (req[pos] && !valid) begin
                valid = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/redmule_stream_arbiter.sv
// Burst arbiter for the X/W/Y/Z streams sharing one memory port.
// Define REDMULE_ARB_AGING_EN to promote long-waiting requesters to the priority group.
module redmule_stream_arbiter
    import redmule_pkg::*;
#(
    parameter int unsigned N_REQ    = ARB_NREQ,
    parameter int unsigned LEN_W    = ARB_LEN_W,
    parameter int unsigned MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*LEN_W-1:0]   len_i,
    input  logic [N_REQ-1:0]         prio_i,
    input  logic                     mem_hs_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] sel_o,
    output logic [N_REQ-1:0]         done_o,
    output logic                     busy_o
);

    localparam int unsigned SelW = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [SelW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  done;
    logic [N_REQ-1:0]  aged;
    logic [N_REQ-1:0]  elig;
    logic [SelW-1:0]   sel_next, arb_start;
    logic              hi_valid, lo_valid, win_valid, arb_en;
    logic [SelW-1:0]   hi_idx, lo_idx, win_idx;
    logic [LEN_W-1:0]  win_len;

    // The completing requester is masked so back-to-back arbitration hands the port on.
    assign elig      = req_i & ((state_q == ArbBurst) ? ~gnt_q : {N_REQ{1'b1}});
    assign sel_next  = SelW'(arb_wrap_inc(32'(sel_q), N_REQ));
    assign arb_start = (state_q == ArbBurst) ? sel_next : ptr_q;

    redmule_rr_pick #(
        .N     (N_REQ),
        .IDX_W (SelW)
    ) u_pick_hi (
        .req   (elig & (prio_i | aged)),
        .start (arb_start),
        .valid (hi_valid),
        .idx   (hi_idx)
    );

    redmule_rr_pick #(
        .N     (N_REQ),
        .IDX_W (SelW)
    ) u_pick_lo (
        .req   (elig),
        .start (arb_start),
        .valid (lo_valid),
        .idx   (lo_idx)
    );

    assign win_valid = hi_valid | lo_valid;
    assign win_idx   = hi_valid ? hi_idx : lo_idx;
    assign win_len   = len_i[32'(win_idx)*LEN_W +: LEN_W];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        done    = '0;
        arb_en  = 1'b0;
        unique case (state_q)
            ArbIdle: arb_en = 1'b1;
            ArbBurst: begin
                if (mem_hs_i) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        done[sel_q] = 1'b1;
                        ptr_d       = sel_next;
                        arb_en      = 1'b1;
                        state_d     = ArbIdle;
                        gnt_d       = '0;
                    end
                end
            end
        endcase
        if (arb_en && win_valid) begin
            // Zero-length bursts complete immediately and are never granted.
            if (win_len == '0) begin
                done[win_idx] = 1'b1;
                ptr_d         = SelW'(arb_wrap_inc(32'(win_idx), N_REQ));
            end else begin
                state_d        = ArbBurst;
                gnt_d          = '0;
                gnt_d[win_idx] = 1'b1;
                sel_d          = win_idx;
                cnt_d          = win_len;
            end
        end
        if (clear_i) begin
            state_d = ArbIdle;
            gnt_d   = '0;
            cnt_d   = '0;
            ptr_d   = '0;
            done    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ArbIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef REDMULE_ARB_AGING_EN
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic [N_REQ-1:0][WaitW-1:0] wait_q, wait_d;

    always_comb begin
        aged = '0;
        for (int i = 0; i < N_REQ; i++) begin
            aged[i] = (wait_q[i] == WaitW'(MAX_WAIT));
        end
    end

    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (clear_i || (gnt_d[i] && !gnt_q[i])) begin
                wait_d[i] = '0;
            end else if (req_i[i] && !gnt_q[i] && !aged[i]) begin
                wait_d[i] = wait_q[i] + WaitW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign aged = '0;
`endif

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign done_o = done;
    assign busy_o = (state_q == ArbBurst);

endmodule

// File: tb/tb_redmule_stream_arbiter.sv
// Self-checking bench for redmule_stream_arbiter: directed table, corner sequences, random vs model.
module tb_redmule_stream_arbiter;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear = 1'b0;
    logic        hs = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  prio = '0;
    logic [63:0] lens = '0;
    logic [3:0]  gnt, done;
    logic [1:0]  sel;
    logic        busy;

    int checks = 0;
    int failures = 0;

    redmule_stream_arbiter #(
        .N_REQ    (4),
        .LEN_W    (16),
        .MAX_WAIT (MW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .clear_i  (clear),
        .req_i    (req),
        .len_i    (lens),
        .prio_i   (prio),
        .mem_hs_i (hs),
        .gnt_o    (gnt),
        .sel_o    (sel),
        .done_o   (done),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [3:0]  req;
        logic [3:0]  prio;
        logic        hs;
        logic [63:0] lens;
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic [3:0]  done;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: who owns the port, beats left, round-robin pointer, wait ages.
    bit         m_busy = 0;
    int         m_own = 0, m_cnt = 0, m_ptr = 0;
    int         m_wait[4] = '{0, 0, 0, 0};
    logic [3:0] m_done = '0;
    bit         use_model = 0;
    logic [3:0] obs_gnt, obs_done;
    logic [1:0] obs_sel;
    logic       obs_busy;

    function automatic logic [63:0] mk(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic vec_t v(input logic c, input logic [3:0] r, input logic [3:0] p,
                               input logic h, input logic [63:0] l, input logic [3:0] g,
                               input logic [1:0] s, input logic [3:0] d, input logic b);
        vec_t x;
        x.clr = c; x.req = r; x.prio = p; x.hs = h; x.lens = l;
        x.gnt = g; x.sel = s; x.done = d; x.busy = b;
        return x;
    endfunction

    function automatic int pick(input logic [3:0] vec, input int start);
        for (int off = 0; off < 4; off++) begin
            if (vec[(start + off) % 4]) return (start + off) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic [3:0] r, input logic [3:0] p, input logic h,
                        input logic [63:0] l);
        logic [3:0] eg, ed, elig, aged;
        int         excl, start, w, lenw, n_own, n_cnt, n_ptr;
        int         n_wait[4];
        bit         arb, n_busy, newly, held;
        clear = c; req = r; prio = p; hs = h; lens = l;
        #1;
        obs_gnt = gnt; obs_sel = sel; obs_done = done; obs_busy = busy;
        eg = m_busy ? 4'(1 << m_own) : 4'b0;
        ed = '0; arb = 0; excl = -1; start = m_ptr;
        n_busy = m_busy; n_own = m_own; n_cnt = m_cnt; n_ptr = m_ptr;
        if (!m_busy) begin
            arb = 1;
        end else if (h) begin
            if (m_cnt == 1) begin
                ed[m_own] = 1'b1;
                n_ptr = (m_own + 1) % 4;
                start = n_ptr;
                excl = m_own;
                arb = 1;
                n_busy = 0;
            end else begin
                n_cnt = m_cnt - 1;
            end
        end
        aged = '0;
`ifdef REDMULE_ARB_AGING_EN
        for (int i = 0; i < 4; i++) aged[i] = (m_wait[i] == MW);
`endif
        if (arb) begin
            elig = r;
            if (excl >= 0) elig[excl] = 1'b0;
            w = pick(elig & (p | aged), start);
            if (w < 0) w = pick(elig, start);
            if (w >= 0) begin
                lenw = int'(l[w*16 +: 16]);
                if (lenw == 0) begin
                    ed[w] = 1'b1;
                    n_ptr = (w + 1) % 4;
                end else begin
                    n_busy = 1; n_own = w; n_cnt = lenw;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            held  = m_busy && (m_own == i);
            newly = n_busy && (n_own == i) && !held;
            if (newly) n_wait[i] = 0;
            else if (r[i] && !held) n_wait[i] = (m_wait[i] + 1 > MW) ? MW : m_wait[i] + 1;
            else n_wait[i] = m_wait[i];
        end
        if (c) begin
            n_busy = 0; n_cnt = 0; n_ptr = 0; ed = '0;
            for (int i = 0; i < 4; i++) n_wait[i] = 0;
        end
        if (use_model) begin
            check("model gnt", 32'(obs_gnt), 32'(eg));
            check("model busy", 32'(obs_busy), 32'(m_busy));
            check("model done", 32'(obs_done), 32'(ed));
            if (m_busy) check("model sel", 32'(obs_sel), 32'(m_own));
        end
        m_busy = n_busy; m_own = n_own; m_cnt = n_cnt; m_ptr = n_ptr; m_done = ed;
        for (int i = 0; i < 4; i++) m_wait[i] = n_wait[i];
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a, b, cl, d, one;
        int          first;
        bit          pend[4];
        int          plen[4];
        bit          pp[4];
        logic [3:0]  rr, pv;
        logic [63:0] ll;

        a = mk(3, 0, 0, 0); b = mk(2, 2, 2, 2); cl = mk(1, 1, 1, 1); d = mk(1, 1, 0, 1);
        one = mk(1, 1, 1, 1);

        #3;
        check("reset gnt", 32'(gnt), 0);
        check("reset sel", 32'(sel), 0);
        check("reset done", 32'(done), 0);
        check("reset busy", 32'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Single burst of 3 beats, handshake held high (also ignored while idle).
        tbl.push_back(v(0, 4'b0001, 4'b0000, 1, a, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 1, a, 4'b0001, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 1, a, 4'b0001, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 1, a, 4'b0001, 0, 4'b0001, 1));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 1, a, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 4'b0000, 0, a, 4'b0000, 0, 4'b0000, 0));
        // All four requesting, back-to-back grants 0..3 with one stall cycle.
        tbl.push_back(v(0, 4'b1111, 4'b0000, 1, b, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1111, 4'b0000, 1, b, 4'b0001, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0000, 0, b, 4'b0001, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b1111, 4'b0000, 1, b, 4'b0001, 0, 4'b0001, 1));
        tbl.push_back(v(0, 4'b1110, 4'b0000, 1, b, 4'b0010, 1, 4'b0000, 1));
        tbl.push_back(v(0, 4'b1110, 4'b0000, 1, b, 4'b0010, 1, 4'b0010, 1));
        tbl.push_back(v(0, 4'b1100, 4'b0000, 1, b, 4'b0100, 2, 4'b0000, 1));
        tbl.push_back(v(0, 4'b1100, 4'b0000, 1, b, 4'b0100, 2, 4'b0100, 1));
        tbl.push_back(v(0, 4'b1000, 4'b0000, 1, b, 4'b1000, 3, 4'b0000, 1));
        tbl.push_back(v(0, 4'b1000, 4'b0000, 1, b, 4'b1000, 3, 4'b1000, 1));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 1, b, 4'b0000, 0, 4'b0000, 0));
        // Priority requester 1 beats requester 0 with the pointer at 0.
        tbl.push_back(v(0, 4'b0011, 4'b0010, 1, cl, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0011, 4'b0010, 1, cl, 4'b0010, 1, 4'b0010, 1));
        tbl.push_back(v(0, 4'b0001, 4'b0000, 1, cl, 4'b0001, 0, 4'b0001, 1));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 1, cl, 4'b0000, 0, 4'b0000, 0));
        // Zero-length burst: done pulse without a grant.
        tbl.push_back(v(0, 4'b0100, 4'b0000, 1, d, 4'b0000, 0, 4'b0100, 0));
        tbl.push_back(v(0, 4'b0000, 4'b0000, 1, d, 4'b0000, 0, 4'b0000, 0));

        foreach (tbl[k]) begin
            step(tbl[k].clr, tbl[k].req, tbl[k].prio, tbl[k].hs, tbl[k].lens);
            check($sformatf("tbl%0d gnt", k), 32'(obs_gnt), 32'(tbl[k].gnt));
            check($sformatf("tbl%0d done", k), 32'(obs_done), 32'(tbl[k].done));
            check($sformatf("tbl%0d busy", k), 32'(obs_busy), 32'(tbl[k].busy));
            if (tbl[k].busy) check($sformatf("tbl%0d sel", k), 32'(obs_sel), 32'(tbl[k].sel));
        end

        // Clear after 2 of 5 beats of requester 2 (pointer sits at 3 here).
        step(0, 4'b0100, 4'b0000, 0, mk(0, 0, 5, 0));
        step(0, 4'b0100, 4'b0000, 1, mk(0, 0, 5, 0));
        check("clr granted", 32'(obs_gnt), 32'h4);
        step(0, 4'b0100, 4'b0000, 1, mk(0, 0, 5, 0));
        step(1, 4'b0100, 4'b0000, 1, mk(0, 0, 5, 0));
        check("clr no done", 32'(obs_done), 0);
        step(0, 4'b1111, 4'b0000, 0, one);
        check("clr gnt low", 32'(obs_gnt), 0);
        check("clr busy low", 32'(obs_busy), 0);
        step(0, 4'b1111, 4'b0000, 0, one);
        check("clr ptr restart", 32'(obs_gnt), 32'h1);
        step(1, 4'b0000, 4'b0000, 0, one);

        // Requesters 0 and 1 keep a priority stream going; requester 3 waits without priority.
        first = -1;
        for (int k = 0; k < 40; k++) begin
            step(0, 4'b1011, 4'b0011, 1, one);
            if (first < 0 && obs_gnt[3]) first = k;
        end
`ifdef REDMULE_ARB_AGING_EN
        check("aging z granted", 32'(first >= 0 && first <= 8), 1);
`else
        check("z starves", 32'(first < 0), 1);
`endif
        step(1, 4'b0000, 4'b0000, 0, one);

        // Random traffic against the model; requesters hold req/len until their done.
        use_model = 1;
        for (int i = 0; i < 4; i++) begin pend[i] = 0; plen[i] = 0; pp[i] = 0; end
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    plen[i] = $urandom_range(0, 4);
                    pp[i]   = ($urandom_range(0, 3) == 0);
                end
            end
            rr = '0; pv = '0; ll = '0;
            for (int i = 0; i < 4; i++) begin
                rr[i] = pend[i];
                pv[i] = pend[i] & pp[i];
                ll[i*16 +: 16] = 16'(plen[i]);
            end
            step($urandom_range(0, 79) == 0, rr, pv, $urandom_range(0, 3) != 0, ll);
            for (int i = 0; i < 4; i++) if (m_done[i]) pend[i] = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
